// File: rtl/decode_seq_pkg.sv
// ---------------------------------------------------------------------------
// decode_seq_pkg
// Shared definitions for the instruction decode sequencer:
//   - bit positions of the one-hot-per-function control word
//   - opcode constants
//   - pc_sel codes
//   - sequencer state encoding and branch classes
//   - a small helper that builds a single-bit control mask
// ---------------------------------------------------------------------------
package decode_seq_pkg;

    // Width of the architected part of the control word.
    localparam int W_RANDLOGIC = 13;

    // Control word bit positions.
    localparam int CTRL_REGWE   = 0;
    localparam int CTRL_ALU     = 1;
    localparam int CTRL_IMMADD  = 2;
    localparam int CTRL_ADDI    = 3;
    localparam int CTRL_MEMWE   = 4;
    localparam int CTRL_MEM2REG = 5;
    localparam int CTRL_IMM2PC  = 6;
    localparam int CTRL_REG2PC  = 7;
    localparam int CTRL_JAL     = 8;
    localparam int CTRL_BNE     = 9;
    localparam int CTRL_BLT     = 10;
    localparam int CTRL_SETX    = 11;
    localparam int CTRL_BEX     = 12;

    // Opcodes.
    localparam logic [4:0] OPC_ALU  = 5'b00000;
    localparam logic [4:0] OPC_J    = 5'b00001;
    localparam logic [4:0] OPC_BNE  = 5'b00010;
    localparam logic [4:0] OPC_JAL  = 5'b00011;
    localparam logic [4:0] OPC_JR   = 5'b00100;
    localparam logic [4:0] OPC_ADDI = 5'b00101;
    localparam logic [4:0] OPC_BLT  = 5'b00110;
    localparam logic [4:0] OPC_SW   = 5'b00111;
    localparam logic [4:0] OPC_LW   = 5'b01000;
    localparam logic [4:0] OPC_SETX = 5'b10101;
    localparam logic [4:0] OPC_BEX  = 5'b10110;

    // Next-PC source selection.
    localparam logic [1:0] PC_SEL_NEXT = 2'd0;  // PC+1
    localparam logic [1:0] PC_SEL_REL  = 2'd1;  // PC+1+imm
    localparam logic [1:0] PC_SEL_IMM  = 2'd2;  // immediate target
    localparam logic [1:0] PC_SEL_REG  = 2'd3;  // register target

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MEM  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // How an instruction affects the PC.
    typedef enum logic [2:0] {
        BR_NONE = 3'd0,  // falls through to PC+1
        BR_BNE  = 3'd1,  // relative, taken on rd != rs
        BR_BLT  = 3'd2,  // relative, taken on rd < rs
        BR_BEX  = 3'd3,  // absolute, taken on $rstatus != 0
        BR_JUMP = 3'd4,  // absolute, always taken (j / jal)
        BR_REG  = 3'd5   // register target (jr)
    } br_class_t;

    // Single-bit mask at position idx within the architected control word.
    function automatic logic [W_RANDLOGIC-1:0] ctrl_bit(input int idx);
        logic [W_RANDLOGIC-1:0] mask;
        mask = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/decode_seq_opc_decode.sv
// ---------------------------------------------------------------------------
// opc_decode
// Purely combinational opcode decoder.
// Ports:
//   opcode   in  5   instruction opcode
//   ctrl     out 13  one-hot-per-function control word (0 for undefined)
//   illegal  out 1   opcode is not defined
//   is_mem   out 1   opcode is lw or sw (needs the memory wait phase)
//   br_class out 3   branch class (decode_seq_pkg::br_class_t encoding)
// ---------------------------------------------------------------------------
module opc_decode
    import decode_seq_pkg::*;
(
    input  logic [4:0]             opcode,
    output logic [W_RANDLOGIC-1:0] ctrl,
    output logic                   illegal,
    output logic                   is_mem,
    output logic [2:0]             br_class
);

    // Undefined opcodes fall to the default arm: NOP control word and a
    // plain PC+1 fall-through, flagged as illegal.
    always_comb begin
        ctrl     = '0;
        illegal  = 1'b0;
        is_mem   = 1'b0;
        br_class = BR_NONE;
        unique case (opcode)
            OPC_ALU: begin
                ctrl = ctrl_bit(CTRL_REGWE) | ctrl_bit(CTRL_ALU);
            end
            OPC_J: begin
                ctrl     = ctrl_bit(CTRL_IMM2PC);
                br_class = BR_JUMP;
            end
            OPC_BNE: begin
                ctrl     = ctrl_bit(CTRL_IMMADD) | ctrl_bit(CTRL_BNE);
                br_class = BR_BNE;
            end
            OPC_JAL: begin
                ctrl     = ctrl_bit(CTRL_REGWE) | ctrl_bit(CTRL_IMM2PC)
                         | ctrl_bit(CTRL_JAL);
                br_class = BR_JUMP;
            end
            OPC_JR: begin
                ctrl     = ctrl_bit(CTRL_REG2PC);
                br_class = BR_REG;
            end
            OPC_ADDI: begin
                ctrl = ctrl_bit(CTRL_REGWE) | ctrl_bit(CTRL_IMMADD)
                     | ctrl_bit(CTRL_ADDI);
            end
            OPC_BLT: begin
                ctrl     = ctrl_bit(CTRL_IMMADD) | ctrl_bit(CTRL_BLT);
                br_class = BR_BLT;
            end
            OPC_SW: begin
                ctrl   = ctrl_bit(CTRL_IMMADD) | ctrl_bit(CTRL_MEMWE);
                is_mem = 1'b1;
            end
            OPC_LW: begin
                ctrl   = ctrl_bit(CTRL_REGWE) | ctrl_bit(CTRL_IMMADD)
                       | ctrl_bit(CTRL_MEM2REG);
                is_mem = 1'b1;
            end
            OPC_SETX: begin
                ctrl = ctrl_bit(CTRL_REGWE) | ctrl_bit(CTRL_SETX);
            end
            OPC_BEX: begin
                ctrl     = ctrl_bit(CTRL_BEX);
                br_class = BR_BEX;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_seq.sv
// ---------------------------------------------------------------------------
// decode_seq
// Multi-cycle instruction sequencer: accepts one opcode at a time in IDLE,
// decodes it, optionally waits MEM_LAT cycles for lw/sw, and retires it in
// DONE with a one-cycle done pulse and the next-PC selection.
// Parameters:
//   W_CTRL   control word width (>= 13, bits above 12 are always 0)
//   MEM_LAT  memory wait cycles for lw/sw (1..15)
//   W_CNT    retired-instruction counter width
// Ports:
//   clock        in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   inst_valid   in   opcode offered
//   inst_opcode  in   5-bit opcode
//   inst_ready   out  high only in IDLE
//   cmp_neq      in   rd != rs (used only in EXEC)
//   cmp_lt       in   rd < rs (used only in EXEC)
//   rstatus_nz   in   $rstatus != 0 (used only in EXEC)
//   ctrl_out     out  decoded control word, 0 in IDLE
//   pc_sel       out  next-PC source, valid while done = 1
//   done         out  one-cycle retire pulse
//   err_illegal  out  one-cycle pulse in EXEC for an undefined opcode
//   retire_cnt   out  wrapping count of retired instructions
// ---------------------------------------------------------------------------
module decode_seq
    import decode_seq_pkg::*;
#(
    parameter int W_CTRL  = 13,
    parameter int MEM_LAT = 2,
    parameter int W_CNT   = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              inst_valid,
    input  logic [4:0]        inst_opcode,
    output logic              inst_ready,
    input  logic              cmp_neq,
    input  logic              cmp_lt,
    input  logic              rstatus_nz,
    output logic [W_CTRL-1:0] ctrl_out,
    output logic [1:0]        pc_sel,
    output logic              done,
    output logic              err_illegal,
    output logic [W_CNT-1:0]  retire_cnt
);

    localparam logic [3:0] MEM_LAT_C = 4'(MEM_LAT);

    state_t                 state_q, state_d;
    logic [4:0]             opcode_q, opcode_d;
    logic                   taken_q, taken_d;
    logic [3:0]             mem_cnt_q, mem_cnt_d;
    logic [W_CNT-1:0]       retire_cnt_q, retire_cnt_d;

    logic [W_RANDLOGIC-1:0] dec_ctrl;
    logic                   dec_illegal;
    logic                   dec_is_mem;
    logic [2:0]             dec_br_class;

    // Decode always looks at the latched opcode, so the control word stays
    // stable for the whole instruction regardless of what the bus does.
    opc_decode u_opc_decode (
        .opcode   (opcode_q),
        .ctrl     (dec_ctrl),
        .illegal  (dec_illegal),
        .is_mem   (dec_is_mem),
        .br_class (dec_br_class)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction context and counters. Clearing the memory counter and
    // retire counter on reset means an abandoned instruction leaves no trace.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            opcode_q     <= '0;
            taken_q      <= 1'b0;
            mem_cnt_q    <= '0;
            retire_cnt_q <= '0;
        end else begin
            opcode_q     <= opcode_d;
            taken_q      <= taken_d;
            mem_cnt_q    <= mem_cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // Next-state logic. The memory counter is loaded on the way into MEM
    // and the last MEM cycle is the one that sees a count of 1.
    always_comb begin
        state_d   = state_q;
        mem_cnt_d = mem_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (inst_valid) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (dec_is_mem) begin
                    state_d   = ST_MEM;
                    mem_cnt_d = MEM_LAT_C;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_MEM: begin
                mem_cnt_d = mem_cnt_q - 4'd1;
                if (mem_cnt_q <= 4'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Opcode capture, branch decision and retire counting. The comparator
    // inputs only matter during EXEC; the decision is held until DONE.
    always_comb begin
        opcode_d     = opcode_q;
        taken_d      = taken_q;
        retire_cnt_d = retire_cnt_q;

        if (state_q == ST_IDLE && inst_valid) begin
            opcode_d = inst_opcode;
        end

        if (state_q == ST_EXEC) begin
            unique case (dec_br_class)
                BR_BNE:  taken_d = cmp_neq;
                BR_BLT:  taken_d = cmp_lt;
                BR_BEX:  taken_d = rstatus_nz;
                default: taken_d = 1'b0;
            endcase
        end

        if (state_q == ST_DONE) begin
            retire_cnt_d = retire_cnt_q + W_CNT'(1);
        end
    end

    // Moore outputs decoded from the registered state, so every output
    // drops to its idle value as soon as reset is asserted.
    always_comb begin
        inst_ready  = 1'b0;
        ctrl_out    = '0;
        pc_sel      = PC_SEL_NEXT;
        done        = 1'b0;
        err_illegal = 1'b0;
        retire_cnt  = retire_cnt_q;

        if (state_q == ST_IDLE) begin
            inst_ready = 1'b1;
        end else begin
            ctrl_out[W_RANDLOGIC-1:0] = dec_ctrl;
        end

        if (state_q == ST_EXEC) begin
            err_illegal = dec_illegal;
        end

        if (state_q == ST_DONE) begin
            done = 1'b1;
            unique case (dec_br_class)
                BR_BNE, BR_BLT: pc_sel = taken_q ? PC_SEL_REL : PC_SEL_NEXT;
                BR_BEX:         pc_sel = taken_q ? PC_SEL_IMM : PC_SEL_NEXT;
                BR_JUMP:        pc_sel = PC_SEL_IMM;
                BR_REG:         pc_sel = PC_SEL_REG;
                default:        pc_sel = PC_SEL_NEXT;
            endcase
        end
    end

endmodule

// File: tb/tb_decode_seq.sv
// ---------------------------------------------------------------------------
// tb_decode_seq
// Self-checking bench for decode_seq. Each issued instruction pushes its
// predicted behaviour onto a queue; a negedge monitor pops the entry when it
// sees the handshake and checks every following cycle up to retirement.
// ---------------------------------------------------------------------------
module tb_decode_seq;

    localparam int W_CTRL  = 16;
    localparam int MEM_LAT = 2;
    localparam int W_CNT   = 4;

    logic              clock;
    logic              reset_n;
    logic              inst_valid;
    logic [4:0]        inst_opcode;
    logic              inst_ready;
    logic              cmp_neq;
    logic              cmp_lt;
    logic              rstatus_nz;
    logic [W_CTRL-1:0] ctrl_out;
    logic [1:0]        pc_sel;
    logic              done;
    logic              err_illegal;
    logic [W_CNT-1:0]  retire_cnt;

    typedef struct {
        logic [15:0] ctrl;
        logic [1:0]  pc_sel;
        logic        illegal;
        int          lat;
        logic [3:0]  cnt;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cur;
    int         tests_run    = 0;
    int         tests_failed = 0;
    logic [3:0] exp_cnt      = '0;
    bit         mon_busy     = 1'b0;
    int         mon_cycle    = 0;

    decode_seq #(
        .W_CTRL  (W_CTRL),
        .MEM_LAT (MEM_LAT),
        .W_CNT   (W_CNT)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .inst_valid  (inst_valid),
        .inst_opcode (inst_opcode),
        .inst_ready  (inst_ready),
        .cmp_neq     (cmp_neq),
        .cmp_lt      (cmp_lt),
        .rstatus_nz  (rstatus_nz),
        .ctrl_out    (ctrl_out),
        .pc_sel      (pc_sel),
        .done        (done),
        .err_illegal (err_illegal),
        .retire_cnt  (retire_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Counts one comparison and reports it when it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference behaviour of one instruction, written out from the opcode
    // table with literal control-word values.
    function automatic exp_t predict(input logic [4:0] opc, input logic neq,
                                     input logic lt, input logic nz);
        exp_t e;
        e.ctrl    = 16'h0000;
        e.pc_sel  = 2'd0;
        e.illegal = 1'b0;
        e.lat     = 2;
        e.cnt     = 4'd0;
        case (opc)
            5'b00000: e.ctrl = 16'h0003;
            5'b00001: begin e.ctrl = 16'h0040; e.pc_sel = 2'd2; end
            5'b00010: begin e.ctrl = 16'h0204; e.pc_sel = neq ? 2'd1 : 2'd0; end
            5'b00011: begin e.ctrl = 16'h0141; e.pc_sel = 2'd2; end
            5'b00100: begin e.ctrl = 16'h0080; e.pc_sel = 2'd3; end
            5'b00101: e.ctrl = 16'h000D;
            5'b00110: begin e.ctrl = 16'h0404; e.pc_sel = lt ? 2'd1 : 2'd0; end
            5'b00111: begin e.ctrl = 16'h0014; e.lat = 2 + MEM_LAT; end
            5'b01000: begin e.ctrl = 16'h0025; e.lat = 2 + MEM_LAT; end
            5'b10101: e.ctrl = 16'h0801;
            5'b10110: begin e.ctrl = 16'h1000; e.pc_sel = nz ? 2'd2 : 2'd0; end
            default:  e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    // Issues one instruction. Comparator inputs carry the intended values
    // only during EXEC and their inverse at all other times; inst_valid stays
    // high with junk opcodes while the sequencer is busy.
    task automatic applyStimulus(input logic [4:0] opc, input logic neq,
                                 input logic lt, input logic nz);
        exp_t e;
        int   guard;
        guard = 0;
        while (!inst_ready && guard < 20) begin
            @(posedge clock); #1;
            guard++;
        end
        if (!inst_ready) begin
            checkOutput("ready_timeout", 32'(inst_ready), 32'd1);
            return;
        end
        e = predict(opc, neq, lt, nz);
        exp_cnt = exp_cnt + 4'd1;
        e.cnt = exp_cnt;
        exp_q.push_back(e);

        inst_valid  = 1'b1;
        inst_opcode = opc;
        cmp_neq     = !neq;
        cmp_lt      = !lt;
        rstatus_nz  = !nz;
        @(posedge clock); #1;
        inst_opcode = 5'($urandom_range(0, 31));
        cmp_neq     = neq;
        cmp_lt      = lt;
        rstatus_nz  = nz;
        @(posedge clock); #1;
        inst_opcode = 5'($urandom_range(0, 31));
        cmp_neq     = !neq;
        cmp_lt      = !lt;
        rstatus_nz  = !nz;
        guard = 0;
        while (!done && guard < 20) begin
            @(posedge clock); #1;
            guard++;
        end
        if (!done) begin
            checkOutput("done_timeout", 32'(done), 32'd1);
        end
        @(posedge clock); #1;
        inst_valid  = 1'b0;
        inst_opcode = 5'd0;
    endtask

    // Scoreboard monitor: checks the quiet idle outputs, picks up the next
    // expectation at the handshake, then follows the instruction cycle by
    // cycle until the retire count has been updated.
    always @(negedge clock) begin
        if (!reset_n) begin
            mon_busy = 1'b0;
        end else begin
            if (mon_busy) begin
                mon_cycle++;
                if (mon_cycle <= cur.lat) begin
                    checkOutput("ctrl_out", 32'(ctrl_out), 32'(cur.ctrl));
                    checkOutput("ready_busy", 32'(inst_ready), 32'd0);
                    checkOutput("done", 32'(done), 32'(mon_cycle == cur.lat));
                    checkOutput("err_illegal", 32'(err_illegal),
                                32'((mon_cycle == 1) && cur.illegal));
                    if (mon_cycle == cur.lat) begin
                        checkOutput("pc_sel", 32'(pc_sel), 32'(cur.pc_sel));
                    end
                end else begin
                    checkOutput("retire_cnt", 32'(retire_cnt), 32'(cur.cnt));
                    checkOutput("ready_idle", 32'(inst_ready), 32'd1);
                    mon_busy = 1'b0;
                end
            end
            if (!mon_busy) begin
                checkOutput("idle_quiet", {ctrl_out, pc_sel, done, err_illegal}, 32'd0);
                if (inst_valid && inst_ready) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_accept", 32'(exp_q.size()), 32'd1);
                    end else begin
                        cur       = exp_q.pop_front();
                        mon_busy  = 1'b1;
                        mon_cycle = 0;
                    end
                end
            end
        end
    end

    logic [4:0] tbl_opc [17];
    logic [2:0] tbl_cmp [17];  // {neq, lt, nz}

    initial begin
        tbl_opc[0]  = 5'b00101; tbl_cmp[0]  = 3'b000;  // addi
        tbl_opc[1]  = 5'b01000; tbl_cmp[1]  = 3'b000;  // lw
        tbl_opc[2]  = 5'b00111; tbl_cmp[2]  = 3'b111;  // sw
        tbl_opc[3]  = 5'b00010; tbl_cmp[3]  = 3'b100;  // bne taken
        tbl_opc[4]  = 5'b00010; tbl_cmp[4]  = 3'b011;  // bne not taken
        tbl_opc[5]  = 5'b00110; tbl_cmp[5]  = 3'b010;  // blt taken
        tbl_opc[6]  = 5'b00110; tbl_cmp[6]  = 3'b101;  // blt not taken
        tbl_opc[7]  = 5'b10110; tbl_cmp[7]  = 3'b001;  // bex taken
        tbl_opc[8]  = 5'b10110; tbl_cmp[8]  = 3'b110;  // bex not taken
        tbl_opc[9]  = 5'b00100; tbl_cmp[9]  = 3'b000;  // jr
        tbl_opc[10] = 5'b00001; tbl_cmp[10] = 3'b000;  // j
        tbl_opc[11] = 5'b00011; tbl_cmp[11] = 3'b111;  // jal
        tbl_opc[12] = 5'b00000; tbl_cmp[12] = 3'b000;  // alu
        tbl_opc[13] = 5'b10101; tbl_cmp[13] = 3'b000;  // setx
        tbl_opc[14] = 5'b11111; tbl_cmp[14] = 3'b000;  // undefined
        tbl_opc[15] = 5'b01001; tbl_cmp[15] = 3'b111;  // undefined
        tbl_opc[16] = 5'b01000; tbl_cmp[16] = 3'b000;  // lw, 17th retire

        reset_n     = 1'b0;
        inst_valid  = 1'b0;
        inst_opcode = 5'd0;
        cmp_neq     = 1'b0;
        cmp_lt      = 1'b0;
        rstatus_nz  = 1'b0;

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        checkOutput("rst_ctrl", 32'(ctrl_out), 32'd0);
        checkOutput("rst_flags", {pc_sel, done, err_illegal}, 32'd0);
        checkOutput("rst_cnt", 32'(retire_cnt), 32'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;
        checkOutput("ready_after_rst", 32'(inst_ready), 32'd1);

        // sw abandoned by reset in the middle of its memory wait.
        exp_q.push_back(predict(5'b00111, 1'b0, 1'b0, 1'b0));
        inst_valid  = 1'b1;
        inst_opcode = 5'b00111;
        @(posedge clock); #1;
        inst_valid  = 1'b0;
        @(posedge clock); #1;
        checkOutput("abort_mem_ctrl", 32'(ctrl_out), 32'h0014);
        reset_n = 1'b0;
        #1;
        checkOutput("abort_ctrl", 32'(ctrl_out), 32'd0);
        checkOutput("abort_flags", {pc_sel, done, err_illegal}, 32'd0);
        checkOutput("abort_cnt", 32'(retire_cnt), 32'd0);
        repeat (3) begin
            @(posedge clock); #1;
            checkOutput("abort_no_done", 32'(done), 32'd0);
        end
        reset_n = 1'b1;
        exp_cnt = 4'd0;
        @(posedge clock); #1;
        checkOutput("abort_ready", 32'(inst_ready), 32'd1);
        checkOutput("abort_cnt_after", 32'(retire_cnt), 32'd0);
        checkOutput("abort_queue", 32'(exp_q.size()), 32'd0);

        // Seventeen back-to-back retires; the 4-bit counter wraps to 1.
        for (int i = 0; i < 17; i++) begin
            applyStimulus(tbl_opc[i], tbl_cmp[i][2], tbl_cmp[i][1], tbl_cmp[i][0]);
        end
        repeat (3) @(posedge clock);
        #1;
        checkOutput("cnt_wrap", 32'(retire_cnt), 32'd1);
        checkOutput("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        checkOutput("final_ready", 32'(inst_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/decode_seq.md
DECODE_SEQ -- requirements
Module: decode_seq

Interface
REQ-001 SHALL have parameter W_CTRL, default 13: control-word width; values below 13 are illegal.
REQ-002 SHALL have parameter MEM_LAT, default 2: wait cycles for lw/sw, range 1..15.
REQ-003 SHALL have parameter W_CNT, default 16: retired-instruction counter width.
REQ-004 SHALL have port clock  in  1: single clock, rising edge.
REQ-005 SHALL have port reset_n  in  1: asynchronous, active-low reset.
REQ-006 SHALL have port inst_valid  in  1: opcode offered.
REQ-007 SHALL have port inst_opcode  in  5: instruction opcode.
REQ-008 SHALL have port inst_ready  out  1: sequencer accepts an opcode.
REQ-009 SHALL have port cmp_neq  in  1: rd != rs, sampled in EXEC.
REQ-010 SHALL have port cmp_lt  in  1: rd < rs, sampled in EXEC.
REQ-011 SHALL have port rstatus_nz  in  1: $rstatus != 0, sampled in EXEC.
REQ-012 SHALL have port ctrl_out  out  W_CTRL: one-hot-per-function control word.
REQ-013 SHALL have port pc_sel  out  2: 0 = PC+1, 1 = PC+1+imm, 2 = imm target, 3 = register target.
REQ-014 SHALL have port done  out  1: one-cycle retire pulse; pc_sel is valid only while done = 1.
REQ-015 SHALL have port err_illegal  out  1: one-cycle pulse for an undefined opcode.
REQ-016 SHALL have port retire_cnt  out  W_CNT: count of retired instructions.

Function
REQ-017 SHALL implement the states IDLE, EXEC, MEM and DONE.
REQ-018 SHALL drive inst_ready = 1 only in IDLE.
REQ-019 SHALL, on inst_valid & inst_ready, latch the opcode and enter EXEC on the next edge.
REQ-020 SHALL hold ctrl_out at the decode of the latched opcode in EXEC, MEM and DONE, and at 0 (NOP) in IDLE.
REQ-021 SHALL decode opcodes as follows:
- alu 00000 = REGWE|ALU
- j 00001 = IMM2PC
- bne 00010 = IMMADD|BNE
- jal 00011 = REGWE|IMM2PC|JAL
- jr 00100 = REG2PC
- addi 00101 = REGWE|IMMADD|ADDI
- blt 00110 = IMMADD|BLT
- sw 00111 = IMMADD|MEMWE
- lw 01000 = REGWE|IMMADD|MEM2REG
- setx 10101 = REGWE|SETX
- bex 10110 = BEX
REQ-022 SHALL treat any other opcode as illegal: ctrl_out = 0, err_illegal pulses in EXEC, and the opcode still retires with pc_sel = 0.
REQ-023 SHALL go EXEC -> MEM for lw/sw, and EXEC -> DONE for all other opcodes.
REQ-024 SHALL stay in MEM for exactly MEM_LAT cycles, counted by an internal down-counter, then enter DONE.
REQ-025 SHALL go DONE -> IDLE unconditionally, pulsing done = 1 for exactly one cycle in DONE.
REQ-026 SHALL register the branch decision in EXEC for use in DONE:
- bne taken iff cmp_neq
- blt taken iff cmp_lt
- bex taken iff rstatus_nz
REQ-027 SHALL drive pc_sel in DONE as follows:
- taken bne/blt = 1
- j/jal/taken bex = 2
- jr = 3
- all others = 0
REQ-028 SHALL ignore comparator inputs outside EXEC.
REQ-029 SHALL increment retire_cnt by 1 on each done pulse, wrapping from all-ones to 0.
REQ-030 SHALL give a latency, accept edge to done, of 2 cycles for non-memory ops and 2+MEM_LAT cycles for lw/sw.
REQ-031 SHALL give a minimum issue interval of 3 cycles for non-memory ops.
REQ-032 SHALL ignore inst_valid and inst_opcode while inst_ready = 0; no buffering.
REQ-033 SHALL drive ctrl_out bits above bit 12 to 0 whenever W_CTRL > 13.

Reset
REQ-034 SHALL, on reset_n low, immediately force state = IDLE, ctrl_out = 0, pc_sel = 0, done = 0, err_illegal = 0, retire_cnt = 0 and MEM counter = 0.
REQ-035 SHALL, on reset_n low mid-instruction (EXEC or MEM), abandon the instruction with no done pulse and no count change.
REQ-036 SHALL assert inst_ready on the first clock edge after reset_n releases.

Structure
REQ-037 SHALL place ctrl bit indices in a shared package:
- REGWE=0, ALU=1, IMMADD=2, ADDI=3, MEMWE=4, MEM2REG=5
- IMM2PC=6, REG2PC=7, JAL=8, BNE=9, BLT=10, SETX=11, BEX=12
REQ-038 SHALL place in the same shared package: W_RANDLOGIC=13, the opcode constants, the pc_sel codes and the state encoding.
REQ-039 SHALL contain one combinational sub-module, opc_decode, mapping opcode to {ctrl word, illegal, is_mem, branch class}.
REQ-040 SHALL implement the FSM and counters in decode_seq.

Verification
REQ-041 SHALL verify: addi (00101) offered from IDLE -> ctrl_out = 0x000D in EXEC/DONE, done at accept+2, pc_sel = 0, retire_cnt 0 -> 1.
REQ-042 SHALL verify: lw with MEM_LAT = 2 -> ctrl_out = 0x0025 for 4 cycles, done at accept+4, inst_ready low throughout.
REQ-043 SHALL verify: bne with cmp_neq = 1 in EXEC -> pc_sel = 1; bne with cmp_neq = 0 -> pc_sel = 0; cmp_neq toggled in DONE has no effect.
REQ-044 SHALL verify: bex with rstatus_nz = 1 -> pc_sel = 2; jr -> pc_sel = 3.
REQ-045 SHALL verify: opcode 11111 -> err_illegal pulse in EXEC, ctrl_out = 0, done still pulses, retire_cnt increments.
REQ-046 SHALL verify: reset_n low during MEM of sw -> outputs 0 asynchronously, no done, retire_cnt = 0; W_CNT = 4 with 17 retires -> retire_cnt = 1.
